instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 1024: instruction buffer entries, a power of two of at least 4.
REQ-002 SHALL have parameter INSTR_W, default 32: instruction width in bits.
REQ-003 SHALL have derived parameter AW = log2(DEPTH): PC width.
REQ-004 SHALL have port clk, input, 1 bit: clock.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port load_valid, input, 1 bit: load_data is present this cycle.
REQ-007 SHALL have port load_data, input, INSTR_W bits: instruction word to load.
REQ-008 SHALL have port load_last, input, 1 bit: marks the final word of the program.
REQ-009 SHALL have port out_ready, input, 1 bit: decode accepts the current fetch pair.
REQ-010 SHALL have port out_valid, output, 1 bit: the fetch pair is valid.
REQ-011 SHALL have port instr0, output, INSTR_W bits: instruction at pc.
REQ-012 SHALL have port instr1, output, INSTR_W bits: instruction at pc+1.
REQ-013 SHALL have port instr1_valid, output, 1 bit: the second slot lies inside the program.
REQ-014 SHALL have port pc_out, output, AW bits: current fetch PC.
REQ-015 SHALL have port prog_len, output, AW+1 bits: number of loaded words.
REQ-016 SHALL have port done, output, 1 bit: the program has been fully fetched.
REQ-017 SHALL have port redirect_valid, input, 1 bit, present only under IFU_REDIRECT_EN: redirect request.
REQ-018 SHALL have port redirect_pc, input, AW bits, present only under IFU_REDIRECT_EN: redirect target.

Function
REQ-019 SHALL implement FSM states IDLE, LOAD, FETCH and DONE, with the state register updated on the clk rising edge.
REQ-020 SHALL handle a load_valid in IDLE or DONE by writing the word to address 0, setting wr_ptr to 1, clearing done and entering LOAD (or FETCH if load_last is also set).
REQ-021 SHALL, in LOAD, write each load_valid word to mem[wr_ptr] and increment wr_ptr.
REQ-022 SHALL end loading on load_valid with load_last, set prog_len to words written, and enter FETCH on the next cycle.
REQ-023 SHALL treat a write to address DEPTH-1 as an implicit load_last, so prog_len is at most DEPTH.
REQ-024 SHALL ignore load_valid in FETCH, and ignore out_ready in IDLE, LOAD and DONE.
REQ-025 SHALL, in FETCH, drive out_valid=1, instr0=mem[pc], instr1=mem[(pc+1) mod DEPTH] and instr1_valid=(pc+1 < prog_len); these outputs are combinational from the pc register, with zero-cycle latency.
REQ-026 SHALL drive instr1=0 whenever instr1_valid=0.
REQ-027 SHALL, on out_valid and out_ready, advance pc by 2 if instr1_valid is 1, else by 1, with AW+1-bit arithmetic.
REQ-028 SHALL enter DONE with pc unchanged, instead of wrapping, when the advanced pc is at least prog_len.
REQ-029 SHALL hold pc, instr0 and instr1 stable while out_valid=1 and out_ready=0.
REQ-030 SHALL, in DONE, drive done=1 and out_valid=0; with out_valid=0, instr0, instr1 and instr1_valid are 0.
REQ-031 SHALL drive pc_out = pc in every state.
REQ-032 SHALL fetch in FETCH the first cycle after the last load: the last load write and the fetch read never occur in the same cycle.

Reset
REQ-033 SHALL, on rst, immediately set state=IDLE, pc=0, wr_ptr=0, prog_len=0, out_valid=0, done=0, and set instr0, instr1 and instr1_valid to 0.
REQ-034 SHALL leave buffer memory uncleared on reset; reset mid-load or mid-fetch discards the program (prog_len=0).

Configuration
REQ-035 SHALL, with IFU_REDIRECT_EN defined, in FETCH on redirect_valid, load pc=redirect_pc next cycle, with priority over an out_ready handshake in the same cycle; the current pair is not consumed.
REQ-036 SHALL, with IFU_REDIRECT_EN defined, enter DONE when redirect_pc is at least prog_len, and ignore redirect_valid outside FETCH.
REQ-037 SHALL, with IFU_REDIRECT_EN undefined, omit the redirect ports and advance pc only by REQ-027.

Verification (DEPTH=8)
REQ-038 SHALL verify: load 5 words A..E, last on E, out_ready=1 -> pairs (A,B),(C,D),(E,0 with instr1_valid=0); done=1 on the fourth FETCH-exit cycle; prog_len=5.
REQ-039 SHALL verify: out_ready low 3 cycles during FETCH at pc=2 -> out_valid=1, pc_out=2 and instr0/instr1 stable throughout.
REQ-040 SHALL verify: load 9 words without load_last -> the 8th write terminates loading, prog_len=8, the 9th word is ignored, and the last pair is at pc=6.
REQ-041 SHALL verify: rst asserted mid-load after 3 words -> all outputs zero and state=IDLE asynchronously; a new load then starts at address 0.
REQ-042 SHALL verify: load_valid in DONE -> done=0 and a new program is loaded from address 0, then fetched from pc=0.
REQ-043 SHALL verify, under IFU_REDIRECT_EN: redirect_pc=1 with out_ready=1 at pc=4 -> next pc_out=1; a redirect to 7 with prog_len=5 -> DONE.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: loads a program into a local buffer, then presents
// instruction pairs to decode. Optional redirect support under IFU_REDIRECT_EN.
module instr_fetch_unit #(
   parameter int   DEPTH   = 1024,
   parameter int   INSTR_W = 32,
   localparam int  AW      = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load_valid,
   input  logic [INSTR_W-1:0] load_data,
   input  logic               load_last,
   input  logic               out_ready,
   output logic               out_valid,
   output logic [INSTR_W-1:0] instr0,
   output logic [INSTR_W-1:0] instr1,
   output logic               instr1_valid,
   output logic [AW-1:0]      pc_out,
   output logic [AW:0]        prog_len,
   output logic               done
`ifdef IFU_REDIRECT_EN
   ,
   input  logic               redirect_valid,
   input  logic [AW-1:0]      redirect_pc
`endif
);

   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
   localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
   localparam logic [AW:0]   ONE       = (AW+1)'(1);
   localparam logic [AW:0]   TWO       = (AW+1)'(2);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      FETCH,
      DONE
   } state_t;

   state_t             state_q, state_d;
   logic [AW-1:0]      pc_q, pc_d;
   logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]        prog_len_q, prog_len_d;

   logic [INSTR_W-1:0] mem [DEPTH];
   logic               mem_we;
   logic [AW-1:0]      mem_waddr;

   logic [AW:0]        pc_ext;
   logic [AW:0]        pc_inc1;
   logic [AW:0]        pc_inc2;
   logic [AW:0]        pc_adv;
   logic               slot1_in_prog;

   // PC arithmetic is one bit wider so the end-of-program test cannot wrap.
   always_comb begin
      pc_ext        = {1'b0, pc_q};
      pc_inc1       = pc_ext + ONE;
      pc_inc2       = pc_ext + TWO;
      slot1_in_prog = (pc_inc1 < prog_len_q);
      pc_adv        = slot1_in_prog ? pc_inc2 : pc_inc1;
   end

   always_comb begin
      out_valid    = (state_q == FETCH);
      instr0       = '0;
      instr1       = '0;
      instr1_valid = 1'b0;
      if (out_valid) begin
         instr0       = mem[pc_q];
         instr1_valid = slot1_in_prog;
         if (slot1_in_prog) begin
            instr1 = mem[pc_inc1[AW-1:0]];
         end
      end
      pc_out   = pc_q;
      prog_len = prog_len_q;
      done     = (state_q == DONE);
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      wr_ptr_d   = wr_ptr_q;
      prog_len_d = prog_len_q;
      mem_we     = 1'b0;
      mem_waddr  = wr_ptr_q;

      case (state_q)
         IDLE, DONE: begin
            // A new program always starts at address 0 and discards the old one.
            if (load_valid) begin
               mem_we     = 1'b1;
               mem_waddr  = '0;
               wr_ptr_d   = ADDR_ONE;
               pc_d       = '0;
               prog_len_d = '0;
               if (load_last) begin
                  prog_len_d = ONE;
                  state_d    = FETCH;
               end else begin
                  state_d = LOAD;
               end
            end
         end

         LOAD: begin
            if (load_valid) begin
               mem_we   = 1'b1;
               wr_ptr_d = wr_ptr_q + ADDR_ONE;
               // Filling the final slot ends the program even without load_last.
               if (load_last || (wr_ptr_q == LAST_ADDR)) begin
                  prog_len_d = {1'b0, wr_ptr_q} + ONE;
                  state_d    = FETCH;
               end
            end
         end

         FETCH: begin
`ifdef IFU_REDIRECT_EN
            if (redirect_valid) begin
               if ({1'b0, redirect_pc} >= prog_len_q) begin
                  state_d = DONE;
               end else begin
                  pc_d = redirect_pc;
               end
            end else if (out_ready) begin
               if (pc_adv >= prog_len_q) begin
                  state_d = DONE;
               end else begin
                  pc_d = pc_adv[AW-1:0];
               end
            end
`else
            if (out_ready) begin
               if (pc_adv >= prog_len_q) begin
                  state_d = DONE;
               end else begin
                  pc_d = pc_adv[AW-1:0];
               end
            end
`endif
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         pc_q       <= '0;
         wr_ptr_q   <= '0;
         prog_len_q <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         wr_ptr_q   <= wr_ptr_d;
         prog_len_q <= prog_len_d;
      end
   end

   // Buffer contents survive reset; prog_len alone decides what is valid.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_waddr] <= load_data;
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit (DEPTH=8): queue-based program model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_instr_fetch_unit;

   localparam int DEPTH   = 8;
   localparam int INSTR_W = 32;
   localparam int AW      = 3;

   logic               clk = 1'b0;
   logic               rst;
   logic               load_valid;
   logic [INSTR_W-1:0] load_data;
   logic               load_last;
   logic               out_ready;
   logic               out_valid;
   logic [INSTR_W-1:0] instr0;
   logic [INSTR_W-1:0] instr1;
   logic               instr1_valid;
   logic [AW-1:0]      pc_out;
   logic [AW:0]        prog_len;
   logic               done;
   logic               redirect_valid;
   logic [AW-1:0]      redirect_pc;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   instr_fetch_unit #(
      .DEPTH   (DEPTH),
      .INSTR_W (INSTR_W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .load_valid   (load_valid),
      .load_data    (load_data),
      .load_last    (load_last),
      .out_ready    (out_ready),
      .out_valid    (out_valid),
      .instr0       (instr0),
      .instr1       (instr1),
      .instr1_valid (instr1_valid),
      .pc_out       (pc_out),
      .prog_len     (prog_len),
      .done         (done)
`ifdef IFU_REDIRECT_EN
      ,
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
`endif
   );

   // Behavioural model: the program is a queue of words; phase flags say
   // whether words are being collected, pairs are being served, or all served.
   logic [INSTR_W-1:0] m_prog [$];
   bit m_loading  = 1'b0;
   bit m_fetching = 1'b0;
   bit m_done     = 1'b0;
   int m_pc       = 0;
   int m_len      = 0;
   int m_step;
   bit m_redir;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_prog.delete();
         m_loading  = 1'b0;
         m_fetching = 1'b0;
         m_done     = 1'b0;
         m_pc       = 0;
         m_len      = 0;
      end else if (m_fetching) begin
         m_redir = 1'b0;
`ifdef IFU_REDIRECT_EN
         if (redirect_valid) begin
            m_redir = 1'b1;
            if (int'(redirect_pc) >= m_len) begin
               m_fetching = 1'b0;
               m_done     = 1'b1;
            end else begin
               m_pc = int'(redirect_pc);
            end
         end
`endif
         if (!m_redir && out_ready) begin
            m_step = (m_pc + 1 < m_len) ? 2 : 1;
            if (m_pc + m_step >= m_len) begin
               m_fetching = 1'b0;
               m_done     = 1'b1;
            end else begin
               m_pc = m_pc + m_step;
            end
         end
      end else if (m_loading) begin
         if (load_valid) begin
            m_prog.push_back(load_data);
            if (load_last || m_prog.size() == DEPTH) begin
               m_len      = m_prog.size();
               m_loading  = 1'b0;
               m_fetching = 1'b1;
            end
         end
      end else if (load_valid) begin
         m_prog.delete();
         m_prog.push_back(load_data);
         m_pc   = 0;
         m_len  = 0;
         m_done = 1'b0;
         if (load_last) begin
            m_len      = 1;
            m_fetching = 1'b1;
         end else begin
            m_loading = 1'b1;
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic cmp_model();
      logic [INSTR_W-1:0] e0;
      logic [INSTR_W-1:0] e1;
      logic               e1v;
      e0  = '0;
      e1  = '0;
      e1v = 1'b0;
      if (m_fetching) begin
         e0 = m_prog[m_pc];
         if (m_pc + 1 < m_len) begin
            e1v = 1'b1;
            e1  = m_prog[m_pc + 1];
         end
      end
      chk("model out_valid",    64'(out_valid),    64'(m_fetching));
      chk("model instr0",       64'(instr0),       64'(e0));
      chk("model instr1",       64'(instr1),       64'(e1));
      chk("model instr1_valid", 64'(instr1_valid), 64'(e1v));
      chk("model pc_out",       64'(pc_out),       64'(m_pc));
      chk("model prog_len",     64'(prog_len),     64'(m_len));
      chk("model done",         64'(done),         64'(m_done));
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
      cmp_model();
   endtask

   task automatic load_words(input int n, input bit with_last, input logic [INSTR_W-1:0] base,
                             input int first);
      for (int i = first; i < n; i++) begin
         load_valid = 1'b1;
         load_data  = base + INSTR_W'(i);
         load_last  = with_last && (i == n - 1);
         tick();
      end
      load_valid = 1'b0;
      load_last  = 1'b0;
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, " out_valid"},    64'(out_valid),    64'(0));
      chk({tag, " done"},         64'(done),         64'(0));
      chk({tag, " pc_out"},       64'(pc_out),       64'(0));
      chk({tag, " prog_len"},     64'(prog_len),     64'(0));
      chk({tag, " instr0"},       64'(instr0),       64'(0));
      chk({tag, " instr1"},       64'(instr1),       64'(0));
      chk({tag, " instr1_valid"}, 64'(instr1_valid), 64'(0));
   endtask

   initial begin
      rst            = 1'b1;
      load_valid     = 1'b0;
      load_data      = '0;
      load_last      = 1'b0;
      out_ready      = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      tick();
      tick();
      chk_zero_outputs("reset");
      rst = 1'b0;
      tick();

      // Five words A..E, drained with out_ready held high.
      load_words(5, 1'b1, 32'hA000_0000, 0);
      chk("t1 pc0 instr0",   64'(instr0),   64'h0000_0000_A000_0000);
      chk("t1 pc0 instr1",   64'(instr1),   64'h0000_0000_A000_0001);
      chk("t1 prog_len",     64'(prog_len), 64'd5);
      out_ready = 1'b1;
      tick();
      chk("t1 pc2 instr0",   64'(instr0),   64'h0000_0000_A000_0002);
      chk("t1 pc2 instr1",   64'(instr1),   64'h0000_0000_A000_0003);
      tick();
      chk("t1 pc4 instr0",   64'(instr0),   64'h0000_0000_A000_0004);
      chk("t1 pc4 instr1",   64'(instr1),   64'd0);
      chk("t1 pc4 i1valid",  64'(instr1_valid), 64'd0);
      tick();
      chk("t1 done",         64'(done),      64'd1);
      chk("t1 done valid",   64'(out_valid), 64'd0);
      chk("t1 done pc",      64'(pc_out),    64'd4);
      out_ready = 1'b0;
      tick();

      // Reload from DONE, then stall three cycles at pc=2.
      load_valid = 1'b1;
      load_data  = 32'hB000_0000;
      tick();
      chk("t2 done cleared", 64'(done), 64'd0);
      load_words(5, 1'b1, 32'hB000_0000, 1);
      chk("t2 pc0",          64'(pc_out), 64'd0);
      chk("t2 pc0 instr0",   64'(instr0), 64'h0000_0000_B000_0000);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t2 stall valid",  64'(out_valid), 64'd1);
         chk("t2 stall pc",     64'(pc_out),    64'd2);
         chk("t2 stall instr0", 64'(instr0),    64'h0000_0000_B000_0002);
         chk("t2 stall instr1", 64'(instr1),    64'h0000_0000_B000_0003);
      end
      out_ready = 1'b1;
      tick();
      tick();
      chk("t2 done", 64'(done), 64'd1);
      out_ready = 1'b0;

      // Nine words without load_last: the eighth fills the buffer.
      load_words(9, 1'b0, 32'hC000_0000, 0);
      chk("t3 prog_len",     64'(prog_len), 64'd8);
      chk("t3 pc0 instr0",   64'(instr0),   64'h0000_0000_C000_0000);
      out_ready = 1'b1;
      tick();
      tick();
      tick();
      chk("t3 pc6",          64'(pc_out),       64'd6);
      chk("t3 pc6 instr0",   64'(instr0),       64'h0000_0000_C000_0006);
      chk("t3 pc6 instr1",   64'(instr1),       64'h0000_0000_C000_0007);
      chk("t3 pc6 i1valid",  64'(instr1_valid), 64'd1);
      tick();
      chk("t3 done",         64'(done),   64'd1);
      chk("t3 done pc",      64'(pc_out), 64'd6);
      out_ready = 1'b0;

      // Asynchronous reset after three words of a new load.
      load_words(3, 1'b0, 32'hD000_0000, 0);
      #1 rst = 1'b1;
      #1;
      chk_zero_outputs("t4 midload rst");
      cmp_model();
      tick();
      rst = 1'b0;
      tick();
      load_words(4, 1'b1, 32'hE000_0000, 0);
      chk("t4 reload pc",     64'(pc_out),   64'd0);
      chk("t4 reload instr0", 64'(instr0),   64'h0000_0000_E000_0000);
      chk("t4 reload len",    64'(prog_len), 64'd4);
      out_ready = 1'b1;
      tick();
      chk("t4 pc2 instr0",    64'(instr0),   64'h0000_0000_E000_0002);
      chk("t4 pc2 instr1",    64'(instr1),   64'h0000_0000_E000_0003);
      #1 rst = 1'b1;
      #1;
      chk_zero_outputs("t4 midfetch rst");
      out_ready = 1'b0;
      tick();
      rst = 1'b0;
      tick();

`ifdef IFU_REDIRECT_EN
      // Redirect wins over a same-cycle handshake; out-of-range target ends fetch.
      load_words(5, 1'b1, 32'hF000_0000, 0);
      out_ready = 1'b1;
      tick();
      tick();
      chk("t5 pc4", 64'(pc_out), 64'd4);
      redirect_valid = 1'b1;
      redirect_pc    = 3'd1;
      tick();
      chk("t5 redirect pc",     64'(pc_out), 64'd1);
      chk("t5 redirect instr0", 64'(instr0), 64'h0000_0000_F000_0001);
      chk("t5 redirect instr1", 64'(instr1), 64'h0000_0000_F000_0002);
      redirect_pc = 3'd7;
      tick();
      chk("t5 redirect done",   64'(done),   64'd1);
      chk("t5 redirect done pc", 64'(pc_out), 64'd1);
      tick();
      chk("t5 ignore in done",  64'(done),   64'd1);
      redirect_valid = 1'b0;
      out_ready      = 1'b0;
      tick();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
